// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial frame transmitter.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : serial_pkg

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_r;

    // With a single cycle per bit the count never leaves zero, so tick is constant 1.
    assign tick = (count_r == CNT_LAST);

    // Cycle counter, held at zero while cleared and wrapping on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (tick) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

endmodule : serial_bit_timer

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit, data LSB-first, stop bit.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    tx_state_t        state_r;
    tx_state_t        state_next_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_next_s;
    logic [WIDTH-1:0] shifted_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_next_s;
    logic             line_r;
    logic             line_next_s;
    logic             done_r;
    logic             done_next_s;
    logic             tick_s;
    logic             timer_clear_s;

    assign in_ready      = (state_r == IDLE);
    assign busy          = ~in_ready;
    assign serial_out    = line_r;
    assign done          = done_r;
    assign timer_clear_s = (state_r == IDLE);
    assign shifted_s     = shreg_r >> 1;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear_s),
        .tick (tick_s)
    );

    // Next-state, datapath and next line level; the line is computed from the
    // upcoming state so the registered output lines up with the state register.
    always_comb begin
        state_next_s = state_r;
        shreg_next_s = shreg_r;
        idx_next_s   = idx_r;
        line_next_s  = LINE_IDLE;
        done_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = START;
                    shreg_next_s = in_data;
                    idx_next_s   = {IDX_W{1'b0}};
                    line_next_s  = START_BIT;
                end else begin
                    line_next_s  = LINE_IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_next_s = DATA;
                    line_next_s  = shreg_r[0];
                end else begin
                    line_next_s  = START_BIT;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shreg_next_s = shifted_s;
                    if (idx_r == IDX_LAST) begin
                        state_next_s = STOP;
                        line_next_s  = STOP_BIT;
                    end else begin
                        idx_next_s   = idx_r + IDX_W'(1);
                        line_next_s  = shifted_s[0];
                    end
                end else begin
                    line_next_s = shreg_r[0];
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_next_s = IDLE;
                    done_next_s  = 1'b1;
                    line_next_s  = LINE_IDLE;
                end else begin
                    line_next_s  = STOP_BIT;
                end
            end
            default: begin
                state_next_s = IDLE;
                line_next_s  = LINE_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shift register, bit index and registered line/done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= {WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            line_r  <= LINE_IDLE;
            done_r  <= 1'b0;
        end else begin
            shreg_r <= shreg_next_s;
            idx_r   <= idx_next_s;
            line_r  <= line_next_s;
            done_r  <= done_next_s;
        end
    end

endmodule : serial_frame_tx

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench: two transmitter instances (4 and 1 clocks per bit) against a frame-timeline model.
module tb_serial_frame_tx;

    localparam int W  = 8;
    localparam int CA = 4;
    localparam int CB = 1;
    localparam int FA = (W + 2) * CA;
    localparam int FB = (W + 2) * CB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = 8'h00;
    logic         ready_a, ser_a, busy_a, done_a;
    logic         ready_b, ser_b, busy_b, done_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: position within the current frame (-1 when idle) and the captured word.
    int           pos_a = -1;
    int           pos_b = -1;
    logic [W-1:0] word_a = 8'h00;
    logic [W-1:0] word_b = 8'h00;
    logic         dexp_a = 1'b0;
    logic         dexp_b = 1'b0;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(CA)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
        .in_data(in_data), .serial_out(ser_a), .busy(busy_a), .done(done_a)
    );

    serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(CB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b),
        .in_data(in_data), .serial_out(ser_b), .busy(busy_b), .done(done_b)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_a <= -1; dexp_a <= 1'b0; word_a <= 8'h00;
        end else if (pos_a < 0) begin
            dexp_a <= 1'b0;
            if (in_valid) begin pos_a <= 0; word_a <= in_data; end
        end else if (pos_a == FA - 1) begin
            pos_a <= -1; dexp_a <= 1'b1;
        end else begin
            pos_a <= pos_a + 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_b <= -1; dexp_b <= 1'b0; word_b <= 8'h00;
        end else if (pos_b < 0) begin
            dexp_b <= 1'b0;
            if (in_valid) begin pos_b <= 0; word_b <= in_data; end
        end else if (pos_b == FB - 1) begin
            pos_b <= -1; dexp_b <= 1'b1;
        end else begin
            pos_b <= pos_b + 1;
        end
    end

    function automatic logic exp_line(input int pos, input logic [W-1:0] w, input int c);
        if (pos < 0)           return 1'b1;
        if (pos < c)           return 1'b0;
        if (pos < (W + 1) * c) return w[pos / c - 1];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check("a_line",  32'(ser_a),   32'(exp_line(pos_a, word_a, CA)));
        check("a_ready", 32'(ready_a), 32'(pos_a < 0));
        check("a_busy",  32'(busy_a),  32'(pos_a >= 0));
        check("a_done",  32'(done_a),  32'(dexp_a));
        check("b_line",  32'(ser_b),   32'(exp_line(pos_b, word_b, CB)));
        check("b_ready", 32'(ready_b), 32'(pos_b < 0));
        check("b_busy",  32'(busy_b),  32'(pos_b >= 0));
        check("b_done",  32'(done_b),  32'(dexp_b));
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (!ready_a && n < 200) begin
            step();
            n++;
        end
        check("idle_wait", 32'(ready_a), 32'd1);
    endtask

    // One frame on instance A (and optionally B in lockstep), with optional
    // held valid, mid-frame input change, noise on in_data, or reset abort.
    task automatic frame(input logic [W-1:0] d, input bit keep, input int change_t,
                         input int abort_t, input bit check_b, input bit noise,
                         output int hs_cyc);
        logic [9:0] got_a = 10'h000;
        logic [9:0] got_b = 10'h000;
        int  low = 0, done_at = -1, done_cnt = 0, done_b_at = -1;
        bit  aborted = 1'b0;
        wait_idle_a();
        in_valid = 1'b1;
        in_data  = d;
        hs_cyc   = 0;
        for (int t = 0; t <= FA; t++) begin
            step();
            if (t == 0) begin
                hs_cyc = cyc;
                if (!keep) in_valid = 1'b0;
            end
            if (t == change_t) begin
                in_data  = 8'hC3;
                in_valid = 1'b1;
            end else if (noise && t > 0) begin
                in_data = W'($urandom);
            end
            if (!ready_a) low++;
            if (done_a) begin
                done_cnt++;
                if (done_at < 0) done_at = t;
            end
            if ((t % CA) == 2 && (t / CA) < 10) got_a[t / CA] = ser_a;
            if (t < 10) got_b[t] = ser_b;
            if (done_b && done_b_at < 0) done_b_at = t;
            if (t == abort_t) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            #2 rst = 1'b1;
            #1;
            check("rst_line", 32'(ser_a),   32'd1);
            check("rst_busy", 32'(busy_a),  32'd0);
            check("rst_done", 32'(done_a),  32'd0);
            check("rst_rdy",  32'(ready_a), 32'd1);
            step();
            step();
            rst = 1'b0;
            repeat (3) step();
        end else begin
            check("a_bits",     32'(got_a),    32'({1'b1, d, 1'b0}));
            check("a_rdy_low",  32'(low),      32'(FA));
            check("a_done_at",  32'(done_at),  32'(FA));
            check("a_done_cnt", 32'(done_cnt), 32'd1);
            if (check_b) begin
                check("b_bits",    32'(got_b),     32'({1'b1, d, 1'b0}));
                check("b_done_at", 32'(done_b_at), 32'(FB));
            end
        end
    endtask

    initial begin
        int hs1, hs2, hs_tmp;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        step();
        rst = 1'b0;
        repeat (10) step();

        frame(8'hA5, 1'b0, -1, -1, 1'b1, 1'b0, hs_tmp);

        frame(8'h00, 1'b1, -1, -1, 1'b0, 1'b0, hs1);
        frame(8'hFF, 1'b0, -1, -1, 1'b0, 1'b0, hs2);
        check("b2b_gap", 32'(hs2 - hs1), 32'(FA + 1));
        repeat (15) step();

        frame(8'h3C, 1'b0, 3 * CA, -1, 1'b0, 1'b0, hs_tmp);
        frame(8'hC3, 1'b0, -1, -1, 1'b0, 1'b0, hs_tmp);
        repeat (15) step();

        frame(8'h55, 1'b0, -1, 4 * CA + 1, 1'b0, 1'b0, hs_tmp);
        frame(8'h81, 1'b0, -1, -1, 1'b1, 1'b0, hs_tmp);
        repeat (15) step();

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 5)) step();
            frame(W'($urandom), 1'b0, -1, -1, 1'b1, 1'b1, hs_tmp);
            repeat (12) step();
        end

        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_frame_tx
